univ_shift_reg: RTL and testbench

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

---
 rtl/univ_shift_reg.sv | 126 ++++++++++++
 tb/tb_univ_shift_reg.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg.sv
// ---------------------------------------------------------------------------
// univ_shift_reg
//   Universal shift register with an idle-time operation decoder and a
//   serial transmit burst engine.  While idle, 'mode' selects hold, shift,
//   rotate, parallel load or clear.  A 'start' request loads I_par and
//   shifts it out LSB first on 'sout' over exactly WIDTH cycles.
//
// Parameters
//   WIDTH  : register width in bits (>= 2)
//
// Ports
//   clk    : rising-edge clock
//   rst    : asynchronous reset, active low
//   mode   : idle operation select (ignored during a burst)
//   I_par  : parallel load data
//   sin_r  : serial input entering the MSB on right shifts
//   sin_l  : serial input entering the LSB on left shifts
//   start  : request a transmit burst (takes priority over mode)
//   A_par  : registered register contents
//   sout   : serial output, always A_par[0]
//   busy   : registered, high while a burst is in progress
//   done   : registered one-cycle pulse on burst completion
// ---------------------------------------------------------------------------
module univ_shift_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] I_par,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic             start,
  output logic [WIDTH-1:0] A_par,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  // One extra bit beyond $clog2 keeps the counter from wrapping even when
  // WIDTH is an exact power of two.
  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Next-state logic.  done defaults low so the pulse always lasts exactly
  // one cycle.  A burst ends on the edge where the counter shows the last
  // bit has just been presented.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = I_par;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end else begin
          unique case (mode)
            3'b000: a_d = a_q;
            3'b001: a_d = {sin_r, a_q[WIDTH-1:1]};
            3'b010: a_d = {a_q[WIDTH-2:0], sin_l};
            3'b011: a_d = I_par;
            3'b100: a_d = {a_q[0], a_q[WIDTH-1:1]};
            3'b101: a_d = {a_q[WIDTH-2:0], a_q[WIDTH-1]};
            3'b110: a_d = '0;
            3'b111: a_d = a_q;
          endcase
        end
      end

      SHIFT: begin
        a_d   = {sin_r, a_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State register; reset aborts any burst without a done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign A_par = a_q;
  assign sout  = a_q[0];
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// ---------------------------------------------------------------------------
// tb_univ_shift_reg
//   Drives a WIDTH=4 and a WIDTH=8 instance from shared stimulus.  A
//   behavioural model (integer arithmetic per register) is compared against
//   both instances on every falling edge, and directed sections pin the
//   model with hand-computed values.
// ---------------------------------------------------------------------------
module tb_univ_shift_reg;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] mode = 3'b000;
  logic [3:0] iPar4 = 4'h0;
  logic [7:0] iPar8 = 8'h00;
  logic       sinR = 1'b0;
  logic       sinL = 1'b0;
  logic       start = 1'b0;

  logic [3:0] a4;
  logic       sout4, busy4, done4;
  logic [7:0] a8;
  logic       sout8, busy8, done8;

  int testsRun = 0;
  int testsFailed = 0;

  // Model state per instance: index 0 is WIDTH=4, index 1 is WIDTH=8.
  // bitsLeft counts SHIFT cycles still to go in the current burst.
  int mA[2];
  int mBusy[2];
  int mDone[2];
  int bitsLeft[2];

  always #5 clk = ~clk;

  univ_shift_reg #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .mode(mode), .I_par(iPar4), .sin_r(sinR),
    .sin_l(sinL), .start(start), .A_par(a4), .sout(sout4), .busy(busy4),
    .done(done4)
  );

  univ_shift_reg #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .mode(mode), .I_par(iPar8), .sin_r(sinR),
    .sin_l(sinL), .start(start), .A_par(a8), .sout(sout8), .busy(busy8),
    .done(done8)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // One model step for instance k using the operation rules directly.
  task automatic modelStep(input int k);
    int w, mask, ip, a;
    w    = (k == 0) ? 4 : 8;
    mask = (1 << w) - 1;
    ip   = (k == 0) ? int'(iPar4) : int'(iPar8);
    a    = mA[k];
    mDone[k] = 0;
    if (mBusy[k] != 0) begin
      a = (a >> 1) | (int'(sinR) << (w - 1));
      bitsLeft[k]--;
      if (bitsLeft[k] == 0) begin
        mBusy[k] = 0;
        mDone[k] = 1;
      end
    end else if (start) begin
      a = ip;
      mBusy[k] = 1;
      bitsLeft[k] = w;
    end else begin
      case (mode)
        3'd1: a = (a >> 1) | (int'(sinR) << (w - 1));
        3'd2: a = ((a << 1) & mask) | int'(sinL);
        3'd3: a = ip;
        3'd4: a = (a >> 1) | ((a & 1) << (w - 1));
        3'd5: a = ((a << 1) & mask) | (a >> (w - 1));
        3'd6: a = 0;
        default: a = a;
      endcase
    end
    mA[k] = a & mask;
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        mA[k] = 0; mBusy[k] = 0; mDone[k] = 0; bitsLeft[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) modelStep(k);
    end
  end

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    checkOutput("model a4", int'(a4), mA[0]);
    checkOutput("model sout4", int'(sout4), mA[0] & 1);
    checkOutput("model busy4", int'(busy4), mBusy[0]);
    checkOutput("model done4", int'(done4), mDone[0]);
    checkOutput("model a8", int'(a8), mA[1]);
    checkOutput("model sout8", int'(sout8), mA[1] & 1);
    checkOutput("model busy8", int'(busy8), mBusy[1]);
    checkOutput("model done8", int'(done8), mDone[1]);
  end

  // Set inputs just after a falling edge, then let one rising edge apply them.
  task automatic applyStimulus(input logic [2:0] m, input logic [3:0] p4,
                               input logic [7:0] p8, input logic st,
                               input logic sr, input logic sl);
    mode  = m;
    iPar4 = p4;
    iPar8 = p8;
    start = st;
    sinR  = sr;
    sinL  = sl;
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] exp4;
    logic [7:0] exp8;
    int doneCount4, doneCount8, busyCount4, busyCount8;

    @(negedge clk);
    #1;
    checkOutput("reset a4", int'(a4), 0);
    checkOutput("reset busy4", int'(busy4), 0);
    checkOutput("reset done4", int'(done4), 0);
    checkOutput("reset sout4", int'(sout4), 0);

    // Clock, start and mode have no effect while held in reset.
    applyStimulus(3'b011, 4'hF, 8'hFF, 1'b1, 1'b0, 1'b0);
    checkOutput("in reset a4", int'(a4), 0);
    checkOutput("in reset busy4", int'(busy4), 0);
    rst = 1'b1;

    // Load 0010 then hold.
    applyStimulus(3'b011, 4'b0010, 8'h5A, 1'b0, 1'b0, 1'b0);
    checkOutput("load a4", int'(a4), 4'b0010);
    applyStimulus(3'b000, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("hold1 a4", int'(a4), 4'b0010);
    applyStimulus(3'b000, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("hold2 a4", int'(a4), 4'b0010);

    // Rotate left four times from 1000, then shift right with sin_r=1.
    applyStimulus(3'b011, 4'b1000, 8'h81, 1'b0, 1'b0, 1'b0);
    applyStimulus(3'b101, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("rotl1 a4", int'(a4), 4'b0001);
    applyStimulus(3'b101, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("rotl2 a4", int'(a4), 4'b0010);
    applyStimulus(3'b101, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("rotl3 a4", int'(a4), 4'b0100);
    applyStimulus(3'b101, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("rotl4 a4", int'(a4), 4'b1000);
    applyStimulus(3'b001, 4'h0, 8'h00, 1'b0, 1'b1, 1'b0);
    checkOutput("shr1 a4", int'(a4), 4'b1100);
    applyStimulus(3'b001, 4'h0, 8'h00, 1'b0, 1'b1, 1'b0);
    checkOutput("shr2 a4", int'(a4), 4'b1110);

    // Remaining idle modes exercised against the model.
    applyStimulus(3'b100, 4'h0, 8'h00, 1'b0, 1'b0, 1'b1);
    applyStimulus(3'b010, 4'h0, 8'h00, 1'b0, 1'b0, 1'b1);
    applyStimulus(3'b111, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0);
    applyStimulus(3'b110, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("clear a4", int'(a4), 0);

    // Single bursts on both widths from one start pulse.
    exp4 = 4'b1011;
    exp8 = 8'b10100101;
    applyStimulus(3'b000, exp4, exp8, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      if (i < 4) begin
        checkOutput($sformatf("burst sout4[%0d]", i), int'(sout4), int'(exp4[i]));
        checkOutput($sformatf("burst busy4[%0d]", i), int'(busy4), 1);
      end
      if (i == 4) begin
        checkOutput("burst done4", int'(done4), 1);
        checkOutput("burst end busy4", int'(busy4), 0);
        checkOutput("burst end a4", int'(a4), 0);
      end
      if (i == 5) checkOutput("burst done4 cleared", int'(done4), 0);
      if (i < 8) begin
        checkOutput($sformatf("burst sout8[%0d]", i), int'(sout8), int'(exp8[i]));
        checkOutput($sformatf("burst busy8[%0d]", i), int'(busy8), 1);
      end
      if (i == 8) begin
        checkOutput("burst done8", int'(done8), 1);
        checkOutput("burst end a8", int'(a8), 0);
      end
      if (i == 9) checkOutput("burst done8 cleared", int'(done8), 0);
      applyStimulus(3'b000, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0);
    end

    // Start held high with mode toggling: back-to-back bursts.
    doneCount4 = 0; doneCount8 = 0; busyCount4 = 0; busyCount8 = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(3'($urandom_range(0, 7)), 4'b0110, 8'b01100110, 1'b1,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      doneCount4 += int'(done4);
      doneCount8 += int'(done8);
      busyCount4 += int'(busy4);
      busyCount8 += int'(busy8);
    end
    checkOutput("held start done4 count", doneCount4, 4);
    checkOutput("held start busy4 count", busyCount4, 16);
    checkOutput("held start done8 count", doneCount8, 2);
    checkOutput("held start busy8 count", busyCount8, 18);

    for (int i = 0; i < 10; i++)
      applyStimulus(3'b000, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset two shift cycles into a burst.
    applyStimulus(3'b000, 4'b1001, 8'h3C, 1'b1, 1'b1, 1'b0);
    applyStimulus(3'b000, 4'h0, 8'h00, 1'b0, 1'b1, 1'b0);
    applyStimulus(3'b000, 4'h0, 8'h00, 1'b0, 1'b1, 1'b0);
    checkOutput("pre-abort busy4", int'(busy4), 1);
    #2 rst = 1'b0;
    #1;
    checkOutput("abort a4", int'(a4), 0);
    checkOutput("abort busy4", int'(busy4), 0);
    checkOutput("abort done4", int'(done4), 0);
    checkOutput("abort sout4", int'(sout4), 0);
    checkOutput("abort a8", int'(a8), 0);
    checkOutput("abort busy8", int'(busy8), 0);
    @(negedge clk);
    #1;
    applyStimulus(3'b011, 4'hF, 8'hFF, 1'b1, 1'b1, 1'b0);
    checkOutput("abort hold a4", int'(a4), 0);
    checkOutput("abort hold done4", int'(done4), 0);
    rst = 1'b1;

    // Clean burst after release.
    doneCount4 = 0;
    busyCount4 = 0;
    applyStimulus(3'b000, 4'b1001, 8'h3C, 1'b1, 1'b0, 1'b0);
    busyCount4 += int'(busy4);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(3'b010, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0);
      doneCount4 += int'(done4);
      busyCount4 += int'(busy4);
    end
    checkOutput("post-reset done4 count", doneCount4, 1);
    checkOutput("post-reset busy4 count", busyCount4, 4);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
